// File: rtl/video_crop.sv
// -----------------------------------------------------------------------------
// video_crop
//
// Crops a rectangular window out of a raw video stream. A pixel is kept when
// its column lies in [X_START, X_START+X_WIDTH) and its line lies in
// [Y_START, Y_START+Y_HEIGHT). Kept pixels appear one cycle after their input
// cycle. Sync signals are delayed by the same single cycle.
//
// Optional feature (macro VIDEO_CROP_MEAS_EN): frame geometry measurement.
// When the macro is defined, the block reports the line width and frame height
// of the last complete frame and flags frames smaller than the crop window.
// When it is undefined, the measurement ports are tied to 0.
//
// Ports
//   vin_clk      in   1          pixel clock (only clock)
//   rst          in   1          asynchronous active-high reset
//   vin_vs       in   1          vertical sync, rising edge = frame start
//   vin_hs       in   1          horizontal sync, delayed only
//   vin_de       in   1          data enable, one pixel per cycle
//   vin_yc       in   16         pixel data
//   vout_de      out  1          cropped data enable
//   vout_vs      out  1          vin_vs delayed 1 cycle
//   vout_hs      out  1          vin_hs delayed 1 cycle
//   vout_yc      out  16         cropped pixel data, 0 when vout_de low
//   meas_width   out  CNT_WIDTH  active pixels per line, last complete frame
//   meas_height  out  CNT_WIDTH  active lines, last complete frame
//   crop_err     out  1          last measured frame smaller than crop window
//
// Handshake: none. The stream has no backpressure; vin_de qualifies each
// cycle's pixel and vout_de qualifies each output cycle.
// -----------------------------------------------------------------------------
module video_crop #(
    parameter int X_START   = 0,
    parameter int X_WIDTH   = 1280,
    parameter int Y_START   = 0,
    parameter int Y_HEIGHT  = 720,
    parameter int CNT_WIDTH = 12
) (
    input  logic                 vin_clk,
    input  logic                 rst,
    input  logic                 vin_vs,
    input  logic                 vin_hs,
    input  logic                 vin_de,
    input  logic [15:0]          vin_yc,
    output logic                 vout_de,
    output logic                 vout_vs,
    output logic                 vout_hs,
    output logic [15:0]          vout_yc,
    output logic [CNT_WIDTH-1:0] meas_width,
    output logic [CNT_WIDTH-1:0] meas_height,
    output logic                 crop_err
);

    typedef enum logic {
        WAIT_VS = 1'b0,
        ACTIVE  = 1'b1
    } state_t;

    // Window bounds one bit wider than the counters so X_START+X_WIDTH can
    // reach 2^CNT_WIDTH without overflowing.
    localparam logic [CNT_WIDTH:0] X_LO = (CNT_WIDTH+1)'(X_START);
    localparam logic [CNT_WIDTH:0] X_HI = (CNT_WIDTH+1)'(X_START + X_WIDTH);
    localparam logic [CNT_WIDTH:0] Y_LO = (CNT_WIDTH+1)'(Y_START);
    localparam logic [CNT_WIDTH:0] Y_HI = (CNT_WIDTH+1)'(Y_START + Y_HEIGHT);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t               state;
    state_t               state_nxt;
    logic                 vs_d;
    logic                 de_d;
    logic                 vs_rise;
    logic                 de_fall;
    logic [CNT_WIDTH-1:0] x;
    logic [CNT_WIDTH-1:0] y;
    logic [CNT_WIDTH-1:0] x_cur;
    logic [CNT_WIDTH-1:0] y_cur;
    logic [CNT_WIDTH:0]   x_lo;
    logic [CNT_WIDTH:0]   x_hi;
    logic [CNT_WIDTH:0]   y_lo;
    logic [CNT_WIDTH:0]   y_hi;
    logic                 keep;

    assign x_lo = X_LO;
    assign x_hi = X_HI;
    assign y_lo = Y_LO;
    assign y_hi = Y_HI;

    assign vs_rise = vin_vs & ~vs_d;
    assign de_fall = ~vin_de & de_d;

    // -------------------------------------------------------------------------
    // Edge-detect history. vs_d resets high so a vin_vs already high while
    // reset is released is not mistaken for a frame start: cropping only
    // resumes after vin_vs has been seen low and then high again.
    // -------------------------------------------------------------------------
    always_ff @(posedge vin_clk or posedge rst) begin
        if (rst) begin
            vs_d <= 1'b1;
            de_d <= 1'b0;
        end else begin
            vs_d <= vin_vs;
            de_d <= vin_de;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge vin_clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_VS;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and keep decision. A frame-start edge clears the counters
    // before the coincident pixel is judged, so that pixel sits at x=0, y=0
    // and is already eligible even though the state only turns ACTIVE on
    // the following cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        keep      = 1'b0;
        x_cur     = x;
        y_cur     = y;
        if (vs_rise) begin
            x_cur = '0;
            y_cur = '0;
        end
        case (state)
            WAIT_VS: if (vs_rise) state_nxt = ACTIVE;
            ACTIVE:  state_nxt = ACTIVE;
            default: state_nxt = WAIT_VS;
        endcase
        if ((state == ACTIVE || vs_rise) && vin_de &&
            ({1'b0, x_cur} >= x_lo) && ({1'b0, x_cur} < x_hi) &&
            ({1'b0, y_cur} >= y_lo) && ({1'b0, y_cur} < y_hi)) begin
            keep = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Column / line counters, saturating. x holds the index of the pixel in
    // the current cycle; after a line ends it is cleared by the de fall.
    // -------------------------------------------------------------------------
    always_ff @(posedge vin_clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else begin
            if (vs_rise) begin
                x <= vin_de ? CNT_ONE : '0;
            end else if (vin_de) begin
                x <= sat_inc(x);
            end else if (de_fall) begin
                x <= '0;
            end

            if (vs_rise) begin
                y <= '0;
            end else if (de_fall) begin
                y <= sat_inc(y);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output registers: one cycle of latency for data and syncs alike.
    // -------------------------------------------------------------------------
    always_ff @(posedge vin_clk or posedge rst) begin
        if (rst) begin
            vout_de <= 1'b0;
            vout_vs <= 1'b0;
            vout_hs <= 1'b0;
            vout_yc <= 16'h0000;
        end else begin
            vout_de <= keep;
            vout_vs <= vin_vs;
            vout_hs <= vin_hs;
            vout_yc <= keep ? vin_yc : 16'h0000;
        end
    end

`ifdef VIDEO_CROP_MEAS_EN
    // -------------------------------------------------------------------------
    // Frame measurement. last_x remembers the width of the most recently
    // completed line, since x itself is cleared when the line ends. If a line
    // ends on the very cycle of the frame-start edge, the live counters are
    // used so that line is still accounted to the frame it belongs to.
    // -------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] last_x;
    logic [CNT_WIDTH-1:0] mw_q;
    logic [CNT_WIDTH-1:0] mh_q;
    logic                 err_q;
    logic [CNT_WIDTH-1:0] w_new;
    logic [CNT_WIDTH-1:0] h_new;

    assign w_new = de_fall ? x : last_x;
    assign h_new = de_fall ? sat_inc(y) : y;

    always_ff @(posedge vin_clk or posedge rst) begin
        if (rst) begin
            last_x <= '0;
            mw_q   <= '0;
            mh_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            if (de_fall) begin
                last_x <= x;
            end
            // The first edge after reset only starts a frame; there is no
            // complete frame to report until the second one.
            if (vs_rise && state == ACTIVE) begin
                mw_q  <= w_new;
                mh_q  <= h_new;
                err_q <= ({1'b0, w_new} < x_hi) | ({1'b0, h_new} < y_hi);
            end
        end
    end

    assign meas_width  = mw_q;
    assign meas_height = mh_q;
    assign crop_err    = err_q;
`else
    assign meas_width  = '0;
    assign meas_height = '0;
    assign crop_err    = 1'b0;
`endif

endmodule

// File: tb/tb_video_crop.sv
// -----------------------------------------------------------------------------
// tb_video_crop
//
// Two crop instances share one input stream:
//   dut_a: X_START=2, X_WIDTH=4,  Y_START=1, Y_HEIGHT=2, CNT_WIDTH=12
//   dut_b: X_START=0, X_WIDTH=10, Y_START=0, Y_HEIGHT=2, CNT_WIDTH=4
// Expected outputs are derived from the column/line indices the driver itself
// generates, pushed to exp_q when a cycle is driven and popped one clock later.
// -----------------------------------------------------------------------------
module tb_video_crop;

  localparam int W = 38;

`ifdef VIDEO_CROP_MEAS_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        vin_clk = 1'b0;
  logic        rst     = 1'b1;
  logic        vin_vs  = 1'b0;
  logic        vin_hs  = 1'b0;
  logic        vin_de  = 1'b0;
  logic [15:0] vin_yc  = 16'h0;

  always #5 vin_clk = ~vin_clk;

  logic        a_de, a_vs, a_hs, a_err;
  logic [15:0] a_yc;
  logic [11:0] a_mw, a_mh;
  logic        b_de, b_vs, b_hs, b_err;
  logic [15:0] b_yc;
  logic [3:0]  b_mw, b_mh;

  video_crop #(.X_START(2), .X_WIDTH(4), .Y_START(1), .Y_HEIGHT(2), .CNT_WIDTH(12)) dut_a (
    .vin_clk(vin_clk), .rst(rst), .vin_vs(vin_vs), .vin_hs(vin_hs), .vin_de(vin_de),
    .vin_yc(vin_yc), .vout_de(a_de), .vout_vs(a_vs), .vout_hs(a_hs), .vout_yc(a_yc),
    .meas_width(a_mw), .meas_height(a_mh), .crop_err(a_err)
  );

  video_crop #(.X_START(0), .X_WIDTH(10), .Y_START(0), .Y_HEIGHT(2), .CNT_WIDTH(4)) dut_b (
    .vin_clk(vin_clk), .rst(rst), .vin_vs(vin_vs), .vin_hs(vin_hs), .vin_de(vin_de),
    .vin_yc(vin_yc), .vout_de(b_de), .vout_vs(b_vs), .vout_hs(b_hs), .vout_yc(b_yc),
    .meas_width(b_mw), .meas_height(b_mh), .crop_err(b_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          active  = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] out_word();
    return {a_vs, a_hs, b_vs, b_hs, a_de, a_yc, b_de, b_yc};
  endfunction

  function automatic logic [W-1:0] meas_word();
    return W'({a_mw, a_mh, a_err, b_mw, b_mh, b_err});
  endfunction

  task automatic check_meas(input string tag,
                            input logic [11:0] aw, input logic [11:0] ah, input logic ae,
                            input logic [3:0] bw, input logic [3:0] bh, input logic be);
    logic [W-1:0] e;
    e = MEAS ? W'({aw, ah, ae, bw, bh, be}) : '0;
    check(tag, meas_word(), e);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at the falling edge, return at the falling edge)
  // ---------------------------------------------------------------------------
  task automatic step(input logic vs, input logic hs, input logic de,
                      input logic [15:0] yc, input logic ka, input logic kb);
    logic [W-1:0] e;
    vin_vs = vs;
    vin_hs = hs;
    vin_de = de;
    vin_yc = yc;
    exp_q.push_back({vs, hs, vs, hs, ka, ka ? yc : 16'h0, kb, kb ? yc : 16'h0});
    @(posedge vin_clk);
    #1;
    e = exp_q.pop_front();
    check("pix", out_word(), e);
    @(negedge vin_clk);
  endtask

  task automatic vs_pulse();
    active = 1'b1;
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    #1;
    check("rst_out", out_word(), '0);
    check("rst_meas", meas_word(), '0);
    @(negedge vin_clk);
    rst    = 1'b0;
    active = 1'b0;
  endtask

  // One line: two blanking cycles (hsync in the first), then npix pixels with
  // yc = column index. vs_first raises vsync together with the first pixel.
  task automatic send_line(input int line, input int npix, input bit vs_first, input int rst_col);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int c = 0; c < npix; c++) begin
      logic ka;
      logic kb;
      int   cb;
      if (vs_first && c == 0) active = 1'b1;
      cb = (c > 15) ? 15 : c;
      ka = active && (c >= 2) && (c < 6) && (line >= 1) && (line < 3);
      kb = active && (cb < 10) && (line < 2);
      step(vs_first && (c < 2), 1'b0, 1'b1, 16'(c), ka, kb);
      if (c == rst_col) mid_reset();
    end
  endtask

  task automatic send_lines(input int npix);
    for (int l = 0; l < 3; l++) send_line(l, npix, 1'b0, -1);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(negedge vin_clk);
    check("reset_out", out_word(), '0);
    check("reset_meas", meas_word(), '0);
    rst = 1'b0;
    @(negedge vin_clk);

    // Pixels before any frame start must be blanked.
    send_line(0, 8, 1'b0, -1);

    // Frame 1: first edge only enters ACTIVE, no measurement yet.
    vs_pulse();
    check_meas("meas_first_edge", 12'd0, 12'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    send_lines(8);

    // Frame 2: report frame 1 (8x3).
    vs_pulse();
    check_meas("meas_f1", 12'd8, 12'd3, 1'b0, 4'd8, 4'd3, 1'b1);
    send_lines(8);

    // Frame 3: vsync rises together with the first pixel of line 0.
    send_line(0, 8, 1'b1, -1);
    check_meas("meas_f2", 12'd8, 12'd3, 1'b0, 4'd8, 4'd3, 1'b1);
    send_line(1, 8, 1'b0, -1);
    send_line(2, 8, 1'b0, -1);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // Frame 4: 20-pixel lines, dut_b column counter saturates at 15.
    vs_pulse();
    check_meas("meas_f3", 12'd8, 12'd3, 1'b0, 4'd8, 4'd3, 1'b1);
    send_lines(20);

    // Frame 5: reset in the middle of line 1 drops the rest of the frame.
    vs_pulse();
    check_meas("meas_sat", 12'd20, 12'd3, 1'b0, 4'd15, 4'd3, 1'b0);
    send_line(0, 8, 1'b0, -1);
    send_line(1, 8, 1'b0, 3);
    send_line(2, 8, 1'b0, -1);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // Frame 6: first edge after reset restarts cropping, no measurement.
    vs_pulse();
    check_meas("meas_after_rst", 12'd0, 12'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    send_lines(8);

    // Frame 7: report frame 6.
    vs_pulse();
    check_meas("meas_f6", 12'd8, 12'd3, 1'b0, 4'd8, 4'd3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
